// File: rtl/noc_vc_packet_merger_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : noc_vc_packet_merger_if
// Brief    : Handshake bundle between a virtual-channel source and the
//            packet merger: per-VC input flits, per-VC downstream ready,
//            merged output flit and lock status.
// Revision : 1.0 - initial release
// ============================================================================
interface noc_vc_packet_merger_if #(
    parameter int CHANNELS   = 2,
    parameter int FLIT_WIDTH = 32
);
    localparam int c_cw = $clog2(CHANNELS);

    logic [CHANNELS-1:0]                 i_valid;
    logic [CHANNELS-1:0]                 o_ready;
    logic [CHANNELS-1:0][FLIT_WIDTH-1:0] i_flit;
    logic [CHANNELS-1:0]                 o_valid;
    logic [CHANNELS-1:0]                 i_ready;
    logic [FLIT_WIDTH-1:0]               o_flit;
    logic                                o_locked;
    logic [c_cw-1:0]                     o_lock_channel;

    // Traffic source / link side
    modport master (
        output i_valid, i_flit, i_ready,
        input  o_ready, o_valid, o_flit, o_locked, o_lock_channel
    );

    // Merger side
    modport slave (
        input  i_valid, i_flit, i_ready,
        output o_ready, o_valid, o_flit, o_locked, o_lock_channel
    );
endinterface
`default_nettype wire

// File: rtl/noc_vc_packet_merger.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : noc_vc_packet_merger
// Brief    : Merges CHANNELS virtual-channel flit streams onto one output
//            link. Each VC has its own input FIFO; a round-robin arbiter
//            picks one flit per loadable cycle and, in packet mode, holds
//            the grant on one VC from head flit to tail flit.
// Revision : 1.0 - initial release
// ============================================================================
module noc_vc_packet_merger #(
    parameter int CHANNELS    = 2,
    parameter int FLIT_WIDTH  = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int PACKET_MODE = 1,
    parameter int TAIL_BIT    = FLIT_WIDTH - 1
) (
    input wire clk,
    input wire rst,
    noc_vc_packet_merger_if.slave bus
);
    localparam int c_aw = $clog2(FIFO_DEPTH);
    localparam int c_cw = $clog2(CHANNELS);

    localparam logic [0:0] c_st_idle   = 1'b0;
    localparam logic [0:0] c_st_locked = 1'b1;

    logic [CHANNELS-1:0]   w_empty;
    logic [CHANNELS-1:0]   w_full;
    logic [CHANNELS-1:0]   w_push;
    logic [CHANNELS-1:0]   w_req;
    logic [CHANNELS-1:0]   w_gnt;
    logic [FLIT_WIDTH-1:0] w_head [CHANNELS];
    logic [FLIT_WIDTH-1:0] w_head_sel;
    logic                  w_tail;
    logic                  w_load;
    logic                  w_any;
    logic [c_cw-1:0]       w_gnt_idx;
    int                    w_idx;

    logic [CHANNELS-1:0]   r_valid;
    logic [FLIT_WIDTH-1:0] r_flit;
    logic [c_cw-1:0]       r_rr_ptr;
    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic [c_cw-1:0]       r_lock_ch;
    logic [c_cw-1:0]       w_lock_ch_nxt;

    // Ready depends only on FIFO fullness; forced low while reset is held.
    assign bus.o_ready = ~w_full & {CHANNELS{~rst}};

    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_fifo
            logic [FLIT_WIDTH-1:0] r_mem [FIFO_DEPTH];
            logic [c_aw:0]         r_wptr;
            logic [c_aw:0]         r_rptr;

            // Extra MSB distinguishes full from empty when the indices match.
            assign w_empty[g] = (r_wptr == r_rptr);
            assign w_full[g]  = (r_wptr[c_aw] != r_rptr[c_aw]) &&
                                (r_wptr[c_aw-1:0] == r_rptr[c_aw-1:0]);
            assign w_push[g]  = bus.i_valid[g] && bus.o_ready[g];
            assign w_head[g]  = r_mem[r_rptr[c_aw-1:0]];

            // FIFO pointers advance on accept and on grant.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_wptr <= '0;
                    r_rptr <= '0;
                end else begin
                    if (w_push[g]) r_wptr <= r_wptr + 1'b1;
                    if (w_gnt[g])  r_rptr <= r_rptr + 1'b1;
                end
            end

            // Storage is not reset; the pointers define which entries are live.
            always_ff @(posedge clk) begin
                if (w_push[g]) r_mem[r_wptr[c_aw-1:0]] <= bus.i_flit[g];
            end
        end
    endgenerate

    // Output register may take a new flit when empty or when its flit leaves.
    assign w_load     = (r_valid == '0) || ((r_valid & bus.i_ready) != '0);
    assign w_head_sel = w_head[w_gnt_idx];
    assign w_tail     = w_head_sel[TAIL_BIT];

    // Request masking by lock, then round-robin search starting at r_rr_ptr.
    always_comb begin
        w_req     = '0;
        w_gnt     = '0;
        w_any     = 1'b0;
        w_gnt_idx = '0;
        w_idx     = 0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_req[c] = !w_empty[c] && bus.i_ready[c] &&
                       ((r_state == c_st_idle) || (r_lock_ch == c_cw'(c)));
        end
        if (w_load) begin
            for (int i = 0; i < CHANNELS; i++) begin
                w_idx = int'(r_rr_ptr) + i;
                if (w_idx >= CHANNELS) w_idx = w_idx - CHANNELS;
                if (!w_any && w_req[c_cw'(w_idx)]) begin
                    w_any     = 1'b1;
                    w_gnt_idx = c_cw'(w_idx);
                end
            end
        end
        if (w_any) w_gnt[w_gnt_idx] = 1'b1;
    end

    // Output register: load granted flit, or drop valid when nothing granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_flit  <= '0;
        end else if (w_load) begin
            r_valid <= w_gnt;
            if (w_any) r_flit <= w_head_sel;
        end
    end

    // Priority rotates past the winner at the end of each flit or packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_any && ((PACKET_MODE == 0) || w_tail)) begin
            r_rr_ptr <= (w_gnt_idx == c_cw'(CHANNELS - 1)) ? '0 : w_gnt_idx + 1'b1;
        end
    end

    // Lock state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_lock_ch <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_lock_ch <= w_lock_ch_nxt;
        end
    end

    // Lock next state: a non-tail grant opens a packet, a tail grant closes it.
    always_comb begin
        w_state_nxt   = r_state;
        w_lock_ch_nxt = r_lock_ch;
        if ((PACKET_MODE != 0) && w_any) begin
            case (r_state)
                c_st_idle: begin
                    if (!w_tail) begin
                        w_state_nxt   = c_st_locked;
                        w_lock_ch_nxt = w_gnt_idx;
                    end
                end
                c_st_locked: begin
                    if (w_tail) w_state_nxt = c_st_idle;
                end
                default: w_state_nxt = c_st_idle;
            endcase
        end
    end

    assign bus.o_valid        = r_valid;
    assign bus.o_flit         = r_flit;
    assign bus.o_locked       = (r_state == c_st_locked);
    assign bus.o_lock_channel = r_lock_ch;
endmodule
`default_nettype wire

// File: doc/noc_vc_packet_merger.md
# noc_vc_packet_merger

Merges CHANNELS virtual-channel flit streams onto one physical output link, with per-channel input buffering and packet-atomic arbitration. Sits between a router output port and the link register. It replaces single-flit round-robin merging with configurable FIFO depth and an optional mode that holds the grant from head flit to tail flit. Downstream back-pressure is per channel.

## Interface
Parameters:
- CHANNELS, 2, number of virtual channels (≥2).
- FLIT_WIDTH, 32, flit width in bits.
- FIFO_DEPTH, 4, entries per channel input FIFO (power of two, ≥2).
- PACKET_MODE, 1, 1 = grant held until a tail flit is granted; 0 = re-arbitrate every flit.
- TAIL_BIT, FLIT_WIDTH-1, bit index of the tail marker inside a flit.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- i_valid  in  CHANNELS  per-channel input flit valid.
- o_ready  out  CHANNELS  per-channel input ready; a flit is accepted when i_valid[c] and o_ready[c] are both 1.
- i_flit  in  CHANNELS×FLIT_WIDTH  per-channel input flit.
- o_valid  out  CHANNELS  output valid, one-hot or zero; bit c names the VC of o_flit.
- i_ready  in  CHANNELS  per-channel downstream ready.
- o_flit  out  FLIT_WIDTH  output flit.
- o_locked  out  1  packet lock active.
- o_lock_channel  out  $clog2(CHANNELS)  channel holding the lock; valid only when o_locked is 1.

## Operation
- Per-channel FIFO, FIFO_DEPTH entries.
  - o_ready[c] = !full[c], a function of FIFO state only.
  - A pop on a full FIFO does not raise o_ready in the same cycle.
- Output register load enable: load = (o_valid == 0) || ((o_valid & i_ready) != 0).
- Request: req[c] = !empty[c] && i_ready[c] && (!locked || lock_ch == c).
- Grant:
  - Taken only when load = 1: one-hot round-robin over req.
  - When load = 0, grant = 0 and nothing pops.
- On grant to c:
  - Pop FIFO c.
  - o_flit <= head of c; o_valid <= one-hot(c).
- On load with no grant: o_valid <= 0; o_flit holds its value.
- Round-robin pointer:
  - Reset value 0 (channel 0 has highest priority).
  - After a granted flit with PACKET_MODE=0, or a granted tail flit with PACKET_MODE=1, highest priority moves to (c+1) mod CHANNELS.
  - No other event changes the pointer.
- Lock state machine (PACKET_MODE=1), two states:
  - IDLE -> LOCKED(c): granted flit from c has flit[TAIL_BIT] = 0. Sets lock_ch = c.
  - LOCKED(c) -> IDLE: granted flit from c has flit[TAIL_BIT] = 1.
  - A single-flit packet (tail set on the first flit) never enters LOCKED.
  - While LOCKED(c), if FIFO c is empty or i_ready[c] = 0, no channel is granted and a bubble is produced. Other channels never interleave.
- PACKET_MODE=0: lock state stays IDLE; o_locked = 0 constantly.
- Flits within a channel leave in arrival order. The block performs no flit modification.

## Timing
- Reset (rst = 1, asynchronous):
  - o_valid = 0, o_flit = 0, o_locked = 0, o_lock_channel = 0.
  - o_ready = 0 while rst is asserted.
  - All FIFOs empty, pointer 0.
- First cycle after rst deasserts: o_ready = all 1s.
- Reset mid-packet discards all buffered flits and the lock immediately.
- Latency:
  - Flit accepted at edge N is eligible in cycle N+1.
  - It appears on o_valid/o_flit after edge N+1, i.e. 2 cycles minimum.
- Throughput: 1 flit/cycle sustained when the granted channel's i_ready stays 1.
- Output hold: o_valid[c] and o_flit stay stable until i_ready[c] = 1. The block never drops or replaces a presented flit.
- A FIFO write and pop on the same channel in the same cycle is legal when not full; occupancy is unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH; full/empty detection uses an extra wrap bit.

## Test plan
- Reset: rst pulse mid-traffic with data in all FIFOs -> same cycle o_valid = 0 and o_ready = 0; after release o_ready = all 1s; no stale flit ever emitted.
- Fair flit merge (PACKET_MODE=0, CHANNELS=4):
  - Stimulus: all channels continuously valid, i_ready = 1111.
  - Required: output VC order 0,1,2,3,0,…, one flit/cycle, first o_valid 2 cycles after first accept.
- Packet atomicity (PACKET_MODE=1):
  - Stimulus: ch0 sends 3-flit packet (tail on 3rd), ch1 sends 2-flit packet simultaneously.
  - Required: output 0,0,0,1,1; o_locked = 1 with o_lock_channel = 0 during ch0 flits.
- Lock bubble:
  - Stimulus: ch0 head sent, next ch0 flit delayed 3 cycles, ch1 has data.
  - Required: 3 cycles of o_valid = 0; ch1 not granted until ch0 tail is granted.
- Back-pressure:
  - Stimulus: i_ready[1] = 0 for 5 cycles while o_valid = 0010.
  - Required: o_flit stable; ch1 FIFO fills to 4 and o_ready[1] = 0; other channels progress only after the held flit leaves.
- Single-flit packets and wrap: 16 tail-only flits per channel with random i_ready -> never locked, per-channel order preserved across multiple FIFO pointer wraps, no loss or duplication.
